window_sum: RTL and testbench
=============================

WINDOW_SUM -- requirements
Module: window_sum

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 4, window length in samples, power of two, legal range 2..64.
REQ-003 Derived constant LOG_D = log2(DEPTH); SUM_W = DATA_W + LOG_D.
REQ-004 clk  input  1  rising-edge clock, single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in  input  DATA_W  unsigned sample.
REQ-007 in_valid  input  1  sample qualifier; in is accepted only on a rising clk edge with in_valid=1.
REQ-008 mode  input  1  output select: 0 = window sum, 1 = window average.
REQ-009 out  output  SUM_W  unsigned result per mode.
REQ-010 out_valid  output  1  high once at least one sample has been accepted since reset.
REQ-011 count  output  LOG_D+1  number of accepted samples in the window, saturating at DEPTH.
REQ-012 full  output  1  high when count == DEPTH.

Function
REQ-013 Storage: circular buffer of DEPTH entries of DATA_W bits, one write pointer, one running-sum register of SUM_W bits.
REQ-014 Window content: the last DEPTH accepted samples; slots not yet written since reset count as 0.
REQ-015 Accept edge: on an edge with in_valid=1, write in at the pointer, advance the pointer modulo DEPTH, and update sum = sum + in - evicted entry.
REQ-016 Latency: the sample accepted at edge k is included in out immediately after edge k; zero extra cycles.
REQ-017 Hold: on an edge with in_valid=0, buffer, pointer, sum, count and out_valid do not change.
REQ-018 Pointer wrap: after index DEPTH-1 the pointer returns to 0 with no lost or duplicated samples.
REQ-019 Arithmetic: sum never overflows, because DEPTH*(2^DATA_W-1) fits in SUM_W bits; no saturation or wrap logic on sum.
REQ-020 mode=0: out = sum, zero-extended as needed.
REQ-021 mode=1: out = sum >> LOG_D (truncating divide by DEPTH, empty slots counted as 0); upper LOG_D bits of out are 0.
REQ-022 mode is decoded combinationally from the registered sum; a mode change is visible on out without a clock edge and does not alter state.
REQ-023 count: increments by 1 per accepted sample while count < DEPTH, then holds at DEPTH.
REQ-024 out_valid: set on the first accepted sample after reset and held until the next reset.
REQ-025 Reset and in_valid both high on the same edge: reset wins and the sample is discarded.

Reset
REQ-026 On an edge with reset=1: all buffer entries = 0, pointer = 0, sum = 0, count = 0, out_valid = 0, full = 0, so out = 0 in both modes.
REQ-027 Reset mid-window fully discards history; the next accepted sample starts a fresh window, with the other DEPTH-1 slots counting as 0.
REQ-028 Reset held for several cycles keeps every output at its reset value regardless of in, in_valid and mode.

Verification (DATA_W=8, DEPTH=4 unless noted)
REQ-029 Sliding sum: mode=0, in_valid=1, inputs 100,100,0,50,50,250 -> out 100,200,200,250,200,350; count 1,2,3,4,4,4; full first high after the 4th sample.
REQ-030 Reset mid-stream: inputs 10,11,12, then reset=1 with in=13, then 20,10 -> out 10,21,33,0,20,30; out_valid low for exactly the reset cycle.
REQ-031 Width/average: inputs 255 x4 -> out 255,510,765,1020 (no wrap); set mode=1 with no clock edge -> out 255; then 0 x4 with mode=0 -> 765,510,255,0.
REQ-032 Gating: inputs 5,7 with in_valid=1, then 3 cycles with in_valid=0 and in=200, then 9 with in_valid=1 -> out 5,12,12,12,12,21; count holds at 2 during the gap.
REQ-033 Same-edge conflict: reset=1 and in_valid=1 with in=99 -> out 0, count 0; the next sample 4 -> out 4.
REQ-034 DEPTH=8, DATA_W=8: inputs 1..9 -> out 1,3,6,10,15,21,28,36,44; with mode=1 after the 9th sample -> out 5.

Source files
------------

// File: rtl/window_sum.sv
// Sliding-window sum/average over the last DEPTH accepted samples.
// Ports: clk, reset (sync, active-high), in/in_valid (sample in),
//   mode (0=sum, 1=average), out/out_valid (result), count/full (fill).
module window_sum #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int LOG_D  = $clog2(DEPTH),
  localparam int SUM_W  = DATA_W + LOG_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  input  logic              mode,
  output logic [SUM_W-1:0]  out,
  output logic              out_valid,
  output logic [LOG_D:0]    count,
  output logic              full
);

  localparam logic [LOG_D:0] FULL_CNT = (LOG_D+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LOG_D-1:0]  ptr;
  logic [SUM_W-1:0]  sum;
  logic [LOG_D:0]    cnt;
  logic              vld;

  // The slot under ptr holds the oldest sample (or 0 before the
  // window fills), so it is the one leaving the sum. DEPTH is a
  // power of two, so ptr wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr <= '0;
      sum <= '0;
      cnt <= '0;
      vld <= 1'b0;
    end else if (in_valid) begin
      mem[ptr] <= in;
      ptr      <= ptr + 1'b1;
      sum      <= sum + SUM_W'(in) - SUM_W'(mem[ptr]);
      if (cnt != FULL_CNT) cnt <= cnt + 1'b1;
      vld      <= 1'b1;
    end
  end

  assign out       = mode ? (sum >> LOG_D) : sum;
  assign out_valid = vld;
  assign count     = cnt;
  assign full      = (cnt == FULL_CNT);

endmodule

// File: tb/tb_window_sum.sv
// Directed scoreboard bench for window_sum.
// Instances: DEPTH=4 and DEPTH=8, both DATA_W=8.
module tb_window_sum;

  logic        clk = 1'b0;
  logic        reset, in_valid, mode;
  logic [7:0]  in;
  logic [9:0]  out;
  logic        out_valid, full;
  logic [2:0]  count;

  logic        reset8, in_valid8, mode8;
  logic [7:0]  in8;
  logic [10:0] out8;
  logic        out_valid8, full8;
  logic [3:0]  count8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    o;
    int    c;
    int    v;
    int    f;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  window_sum #(.DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .mode(mode), .out(out), .out_valid(out_valid),
    .count(count), .full(full)
  );

  window_sum #(.DATA_W(8), .DEPTH(8)) dut8 (
    .clk(clk), .reset(reset8), .in(in8), .in_valid(in_valid8),
    .mode(mode8), .out(out8), .out_valid(out_valid8),
    .count(count8), .full(full8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pop4();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".out"}, int'(out), e.o);
    chk({e.tag, ".count"}, int'(count), e.c);
    chk({e.tag, ".valid"}, int'(out_valid), e.v);
    chk({e.tag, ".full"}, int'(full), e.f);
  endtask

  task automatic pop8();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty8", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".out"}, int'(out8), e.o);
    chk({e.tag, ".count"}, int'(count8), e.c);
    chk({e.tag, ".valid"}, int'(out_valid8), e.v);
    chk({e.tag, ".full"}, int'(full8), e.f);
  endtask

  task automatic step(input bit r, input bit v, input int d,
                      input bit m, input string tag,
                      input int eo, input int ec, input int ev);
    @(negedge clk);
    reset = r; in_valid = v; in = 8'(d); mode = m;
    sb.push_back('{tag, eo, ec, ev, (ec == 4) ? 1 : 0});
    @(posedge clk);
    #1;
    pop4();
  endtask

  task automatic step8(input bit r, input bit v, input int d,
                       input string tag,
                       input int eo, input int ec, input int ev);
    @(negedge clk);
    reset8 = r; in_valid8 = v; in8 = 8'(d); mode8 = 1'b0;
    sb.push_back('{tag, eo, ec, ev, (ec == 8) ? 1 : 0});
    @(posedge clk);
    #1;
    pop8();
  endtask

  // Mode change with no clock edge: compare shortly after driving it.
  task automatic peek(input bit m, input string tag,
                      input int eo, input int ec);
    @(negedge clk);
    mode = m;
    sb.push_back('{tag, eo, ec, 1, (ec == 4) ? 1 : 0});
    #1;
    pop4();
  endtask

  initial begin
    automatic int s29[6] = '{100, 100, 0, 50, 50, 250};
    automatic int o29[6] = '{100, 200, 200, 250, 200, 350};
    automatic int o34[9] = '{1, 3, 6, 10, 15, 21, 28, 36, 44};

    reset = 1'b1; in_valid = 1'b1; in = 8'd77; mode = 1'b0;
    reset8 = 1'b1; in_valid8 = 1'b0; in8 = '0; mode8 = 1'b0;

    // Reset held with activity on the inputs.
    step(1, 1, 77, 0, "rst_hold0", 0, 0, 0);
    step(1, 1, 201, 1, "rst_hold1", 0, 0, 0);
    step(1, 0, 5, 0, "rst_hold2", 0, 0, 0);

    // Sliding sum with pointer wrap.
    for (int i = 0; i < 6; i++)
      step(0, 1, s29[i], 0, $sformatf("slide%0d", i),
           o29[i], (i < 3) ? i + 1 : 4, 1);

    // Reset mid-stream discards history.
    step(1, 0, 0, 0, "r30_rst", 0, 0, 0);
    step(0, 1, 10, 0, "r30_a", 10, 1, 1);
    step(0, 1, 11, 0, "r30_b", 21, 2, 1);
    step(0, 1, 12, 0, "r30_c", 33, 3, 1);
    step(1, 1, 13, 0, "r30_mid", 0, 0, 0);
    step(0, 1, 20, 0, "r30_d", 20, 1, 1);
    step(0, 1, 10, 0, "r30_e", 30, 2, 1);

    // Full-scale samples, average via mode without a clock edge.
    step(1, 0, 0, 0, "r31_rst", 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 255, 0, $sformatf("max%0d", i),
           255 * (i + 1), i + 1, 1);
    peek(1, "avg_max", 255, 4);
    peek(0, "sum_back", 1020, 4);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, $sformatf("drain%0d", i),
           255 * (3 - i), 4, 1);

    // in_valid gating.
    step(1, 0, 0, 0, "r32_rst", 0, 0, 0);
    step(0, 1, 5, 0, "gate_a", 5, 1, 1);
    step(0, 1, 7, 0, "gate_b", 12, 2, 1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 200, 0, $sformatf("gap%0d", i), 12, 2, 1);
    peek(1, "avg_partial", 3, 2);
    step(0, 1, 9, 0, "gate_c", 21, 3, 1);

    // Reset wins over a same-edge sample.
    step(1, 1, 99, 0, "conflict", 0, 0, 0);
    step(0, 1, 4, 0, "after_conf", 4, 1, 1);

    // DEPTH=8 instance.
    step8(1, 0, 0, "d8_rst", 0, 0, 0);
    for (int i = 0; i < 9; i++)
      step8(0, 1, i + 1, $sformatf("d8_%0d", i + 1),
            o34[i], (i < 8) ? i + 1 : 8, 1);
    @(negedge clk);
    mode8 = 1'b1;
    #1;
    chk("d8_avg", int'(out8), 5);
    chk("d8_avg_cnt", int'(count8), 8);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
